mem_wb_elastic: RTL and testbench

//  Parametrised MEM->WB pipeline register with a valid/ready handshake, a 2-entry skid buffer and flush.

---
 rtl/mem_wb_elastic_pkg.sv | 22 ++
 rtl/mem_wb_elastic.sv | 131 +++++++++++++
 tb/tb_mem_wb_elastic.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_elastic_pkg.sv
// Shared types and helpers for the MEM->WB elastic pipeline register.
// Holds the default bus widths, the occupancy encoding and the x0 write guard.
package mem_wb_elastic_pkg;

   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;
   localparam logic [4:0] ZERO_REG = 5'b00000;

   // Encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } wb_state_e;

   function automatic logic guard_write(input logic write,
                                        input logic addr_is_zero,
                                        input logic zero_guard);
      return write & ~(zero_guard & addr_is_zero);
   endfunction

endpackage

// File: rtl/mem_wb_elastic.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// mem_ready is driven from state only, so WB back-pressure never reaches MEM combinationally.
module mem_wb_elastic
   import mem_wb_elastic_pkg::*;
#(
   parameter int DATA_WIDTH = REG_BUS,
   parameter int ADDR_WIDTH = REG_ADDR_BUS,
   parameter bit ZERO_GUARD = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_write_address,
   input  logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic                  wb_write,
   output logic [ADDR_WIDTH-1:0] wb_write_address,
   output logic [DATA_WIDTH-1:0] wb_write_data
);

   wb_state_e             state_r;
   wb_state_e             state_nxt_s;
   logic                  out_write_r;
   logic [ADDR_WIDTH-1:0] out_addr_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  skid_write_r;
   logic [ADDR_WIDTH-1:0] skid_addr_r;
   logic [DATA_WIDTH-1:0] skid_data_r;
   logic                  out_write_nxt_s;
   logic [ADDR_WIDTH-1:0] out_addr_nxt_s;
   logic [DATA_WIDTH-1:0] out_data_nxt_s;
   logic                  skid_write_nxt_s;
   logic [ADDR_WIDTH-1:0] skid_addr_nxt_s;
   logic [DATA_WIDTH-1:0] skid_data_nxt_s;
   logic                  cap_write_s;
   logic                  acc_s;
   logic                  take_s;

   assign wb_valid         = state_r[0];
   assign mem_ready        = ~state_r[1];
   assign wb_write         = out_write_r & state_r[0];
   assign wb_write_address = out_addr_r;
   assign wb_write_data    = out_data_r;

   assign acc_s       = mem_valid & mem_ready;
   assign take_s      = wb_valid & wb_ready;
   assign cap_write_s = guard_write(mem_write,
                                    (mem_write_address == {ADDR_WIDTH{1'b0}}),
                                    ZERO_GUARD);

   // Next occupancy state and next contents of the output and skid slots.
   always_comb begin
      state_nxt_s      = state_r;
      out_write_nxt_s  = out_write_r;
      out_addr_nxt_s   = out_addr_r;
      out_data_nxt_s   = out_data_r;
      skid_write_nxt_s = skid_write_r;
      skid_addr_nxt_s  = skid_addr_r;
      skid_data_nxt_s  = skid_data_r;
      case (state_r)
         ST_EMPTY: begin
            if (acc_s) begin
               out_write_nxt_s = cap_write_s;
               out_addr_nxt_s  = mem_write_address;
               out_data_nxt_s  = mem_write_data;
               state_nxt_s     = ST_ONE;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (acc_s && take_s) begin
               out_write_nxt_s = cap_write_s;
               out_addr_nxt_s  = mem_write_address;
               out_data_nxt_s  = mem_write_data;
               state_nxt_s     = ST_ONE;
            end else if (acc_s) begin
               skid_write_nxt_s = cap_write_s;
               skid_addr_nxt_s  = mem_write_address;
               skid_data_nxt_s  = mem_write_data;
               state_nxt_s      = ST_FULL;
            end else if (take_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ONE;
            end
         end
         ST_FULL: begin
            if (take_s) begin
               out_write_nxt_s = skid_write_r;
               out_addr_nxt_s  = skid_addr_r;
               out_data_nxt_s  = skid_data_r;
               state_nxt_s     = ST_ONE;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // State and payload registers; flush drops entries but leaves payload bits alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= ST_EMPTY;
         out_write_r  <= 1'b0;
         out_addr_r   <= {ADDR_WIDTH{1'b0}};
         out_data_r   <= {DATA_WIDTH{1'b0}};
         skid_write_r <= 1'b0;
         skid_addr_r  <= {ADDR_WIDTH{1'b0}};
         skid_data_r  <= {DATA_WIDTH{1'b0}};
      end else if (flush) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r      <= state_nxt_s;
         out_write_r  <= out_write_nxt_s;
         out_addr_r   <= out_addr_nxt_s;
         out_data_r   <= out_data_nxt_s;
         skid_write_r <= skid_write_nxt_s;
         skid_addr_r  <= skid_addr_nxt_s;
         skid_data_r  <= skid_data_nxt_s;
      end
   end

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Directed and randomised self-checking bench for mem_wb_elastic.
// A second instance with the x0 guard disabled shares the stimulus.
module tb_mem_wb_elastic;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush;
   logic          mem_valid;
   logic          mem_ready;
   logic          mem_write;
   logic [AW-1:0] mem_write_address;
   logic [DW-1:0] mem_write_data;
   logic          wb_valid;
   logic          wb_ready;
   logic          wb_write;
   logic [AW-1:0] wb_write_address;
   logic [DW-1:0] wb_write_data;

   logic          mem_ready_g0;
   logic          wb_valid_g0;
   logic          wb_write_g0;
   logic [AW-1:0] wb_write_address_g0;
   logic [DW-1:0] wb_write_data_g0;

   int vectors    = 0;
   int miscompares = 0;

   logic [AW+DW:0] q[$];
   logic [AW+DW:0] exp_entry;
   int             seq;

   always #5 clock = ~clock;

   mem_wb_elastic #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_GUARD(1'b1)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_write(wb_write),
      .wb_write_address(wb_write_address), .wb_write_data(wb_write_data)
   );

   mem_wb_elastic #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_GUARD(1'b0)) dut_g0 (
      .clock(clock), .reset(reset), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready_g0), .mem_write(mem_write),
      .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
      .wb_valid(wb_valid_g0), .wb_ready(wb_ready), .wb_write(wb_write_g0),
      .wb_write_address(wb_write_address_g0), .wb_write_data(wb_write_data_g0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_valid = 1'b1;
      mem_write = w;
      mem_write_address = a;
      mem_write_data = d;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; wb_ready = 1'b1;
      send(1'b1, 5'd7, 32'h99);
      seq = 0;

      // 1: reset with mem_valid held high
      step(); step();
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_write", wb_write, 1'b0);
      check("rst_wb_addr", wb_write_address, 5'd0);
      check("rst_wb_data", wb_write_data, 32'h0);
      check("rst_mem_ready", mem_ready, 1'b1);
      reset = 1'b0;
      mem_valid = 1'b0;
      step();
      check("post_rst_empty", wb_valid, 1'b0);

      // 2: streaming four entries back to back
      for (int i = 1; i <= 4; i++) begin
         send(1'b1, AW'(i), DW'(i * 32'h11));
         step();
         check("str_valid", wb_valid, 1'b1);
         check("str_addr", wb_write_address, AW'(i));
         check("str_data", wb_write_data, DW'(i * 32'h11));
         check("str_write", wb_write, 1'b1);
         check("str_ready", mem_ready, 1'b1);
      end
      mem_valid = 1'b0;
      step();
      check("str_drain", wb_valid, 1'b0);
      check("str_drain_write", wb_write, 1'b0);

      // 3: stall into FULL, then release
      send(1'b1, 5'd3, 32'hAA);
      step();
      check("stl_a_valid", wb_valid, 1'b1);
      wb_ready = 1'b0;
      send(1'b1, 5'd4, 32'hBB);
      step();
      mem_valid = 1'b0;
      check("stl_full_ready", mem_ready, 1'b0);
      check("stl_hold_addr", wb_write_address, 5'd3);
      check("stl_hold_data", wb_write_data, 32'hAA);
      wb_ready = 1'b1;
      #1;
      check("stl_no_comb_path", mem_ready, 1'b0);
      wb_ready = 1'b0;
      step();
      check("stl_hold2_valid", wb_valid, 1'b1);
      check("stl_hold2_data", wb_write_data, 32'hAA);
      check("stl_hold2_ready", mem_ready, 1'b0);
      wb_ready = 1'b1;
      step();
      check("stl_b_addr", wb_write_address, 5'd4);
      check("stl_b_data", wb_write_data, 32'hBB);
      check("stl_b_ready", mem_ready, 1'b1);
      step();
      check("stl_empty", wb_valid, 1'b0);

      // 4: flush while FULL
      send(1'b1, 5'd3, 32'hAA);
      step();
      wb_ready = 1'b0;
      send(1'b1, 5'd4, 32'hBB);
      step();
      mem_valid = 1'b0;
      check("fl_full", mem_ready, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_valid", wb_valid, 1'b0);
      check("fl_write", wb_write, 1'b0);
      check("fl_ready", mem_ready, 1'b1);
      wb_ready = 1'b1;
      step();
      check("fl_gone", wb_valid, 1'b0);

      // 5: x0 guard with both parameter settings
      send(1'b1, 5'd0, 32'hDEAD);
      step();
      mem_valid = 1'b0;
      check("g1_valid", wb_valid, 1'b1);
      check("g1_write", wb_write, 1'b0);
      check("g1_data", wb_write_data, 32'hDEAD);
      check("g0_valid", wb_valid_g0, 1'b1);
      check("g0_write", wb_write_g0, 1'b1);
      step();
      check("g0_idle_write", wb_write_g0, 1'b0);

      // reset while FULL: both entries lost
      send(1'b1, 5'd9, 32'h1234);
      step();
      wb_ready = 1'b0;
      send(1'b1, 5'd10, 32'h5678);
      step();
      mem_valid = 1'b0;
      check("rf_full", mem_ready, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      wb_ready = 1'b1;
      check("rf_valid", wb_valid, 1'b0);
      check("rf_write", wb_write, 1'b0);
      check("rf_data", wb_write_data, 32'h0);
      check("rf_ready", mem_ready, 1'b1);
      step();
      check("rf_nothing", wb_valid, 1'b0);

      // 6: random traffic against a FIFO scoreboard
      for (int i = 0; i < 2000; i++) begin
         mem_valid = 1'($urandom_range(0, 1));
         wb_ready  = 1'($urandom_range(0, 1));
         mem_write = 1'($urandom_range(0, 1));
         mem_write_address = AW'($urandom_range(0, 31));
         mem_write_data = DW'(seq);
         #1;
         check("rnd_ready", mem_ready, (q.size() < 2));
         check("rnd_valid", wb_valid, (q.size() > 0));
         if (wb_valid && wb_ready && q.size() > 0) begin
            exp_entry = q.pop_front();
            check("rnd_entry", {wb_write, wb_write_address, wb_write_data}, exp_entry);
         end
         if (mem_valid && mem_ready) begin
            q.push_back({mem_write & (mem_write_address != 5'd0), mem_write_address, mem_write_data});
            seq++;
         end
         step();
      end
      mem_valid = 1'b0;
      wb_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (wb_valid && q.size() > 0) begin
            exp_entry = q.pop_front();
            check("drain_entry", {wb_write, wb_write_address, wb_write_data}, exp_entry);
         end
         step();
      end
      check("drain_sb_empty", q.size(), 0);
      check("drain_dut_empty", wb_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
